// File: rtl/cpu_bus_pkg.sv
// cpu_bus_pkg: shared encodings for the SRAM-style CPU bus arbiter.
package cpu_bus_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;
    typedef enum logic {OWN_INST, OWN_DATA} owner_e;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
endpackage

// File: rtl/arb_pick2.sv
// arb_pick2: combinational two-way grant picker, data port wins ties by default.
// ARB_ROUND_ROBIN_EN: ties go to the port not granted last.
module arb_pick2
    import cpu_bus_pkg::*;
(
    input  logic   inst_req,
    input  logic   data_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  owner_e last_grant,
`endif
    output owner_e winner
);
`ifdef ARB_ROUND_ROBIN_EN
    assign winner = (inst_req && data_req) ? (last_grant == OWN_INST ? OWN_DATA : OWN_INST)
                                           : ((data_req || !inst_req) ? OWN_DATA : OWN_INST);
`else
    assign winner = (data_req || !inst_req) ? OWN_DATA : OWN_INST;
`endif
endmodule

// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one SRAM-like bus between instruction fetch and MEM data, one transaction outstanding.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise the data port has fixed priority.
module sram_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok
);
    state_e state_q, state_d;
    owner_e owner_q, owner_d, pick;
    logic   own_data, own_req, in_addr, accept, done, grant;
    assign own_data = owner_q == OWN_DATA;
    assign own_req  = own_data ? data_req : inst_req;
    assign in_addr  = state_q == S_ADDR;
    assign grant    = state_q == S_IDLE && (inst_req || data_req);
    assign accept   = in_addr && own_req && bus_addr_ok;
    assign done     = bus_data_ok && (accept || state_q == S_DATA);
`ifdef ARB_ROUND_ROBIN_EN
    owner_e last_q, last_d;
    arb_pick2 u_pick (.inst_req(inst_req), .data_req(data_req), .last_grant(last_q), .winner(pick));
    always_comb last_d = grant ? pick : last_q;
    always_ff @(posedge clk) last_q <= rst ? OWN_INST : last_d;
`else
    arb_pick2 u_pick (.inst_req(inst_req), .data_req(data_req), .winner(pick));
`endif
    always_comb begin
        state_d = state_q;
        owner_d = grant ? pick : owner_q;
        if (grant)
            state_d = S_ADDR;
        // a dropped request in ADDR is a protocol violation: abandon quietly
        if (in_addr)
            state_d = !own_req ? S_IDLE : !bus_addr_ok ? S_ADDR : bus_data_ok ? S_IDLE : S_DATA;
        if (state_q == S_DATA && bus_data_ok)
            state_d = S_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_DATA;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end
    assign bus_req      = in_addr && own_req;
    assign bus_wr       = in_addr && (own_data ? data_wr : inst_wr);
    assign bus_size     = in_addr ? (own_data ? data_size : inst_size) : SZ_BYTE;
    assign bus_addr     = in_addr ? (own_data ? data_addr : inst_addr) : '0;
    assign bus_wdata    = in_addr ? (own_data ? data_wdata : inst_wdata) : '0;
    assign inst_addr_ok = accept && !own_data;
    assign data_addr_ok = accept && own_data;
    assign inst_data_ok = done && !own_data;
    assign data_data_ok = done && own_data;
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// tb_sram_bus_arbiter: directed scenarios plus randomized transactions against a transaction-level model.
module tb_sram_bus_arbiter;
    import cpu_bus_pkg::*;
    logic        clk = 1'b0, rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, bus_size;
    logic [31:0] inst_addr, data_addr, bus_addr, inst_wdata, data_wdata, bus_wdata;
    logic [31:0] inst_rdata, data_rdata, bus_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [3:0]  oks;
    int          total = 0, bad = 0;
    owner_e      m_last;
    assign oks = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok};
    always #5 clk = ~clk;
    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
    );
    function automatic owner_e model_pick(logic i, logic d, owner_e last);
`ifdef ARB_ROUND_ROBIN_EN
        if (i && d) return last == OWN_INST ? OWN_DATA : OWN_INST;
`endif
        return d ? OWN_DATA : OWN_INST;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic quiet();
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        bus_rdata = 0; bus_addr_ok = 0; bus_data_ok = 0;
    endtask
    task automatic do_reset();
        tick(); quiet(); rst = 1;
        tick(); rst = 0;
        m_last = OWN_INST;
    endtask
    task automatic test_reset();
        quiet(); rst = 1;
        inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
        inst_addr = $urandom; data_addr = $urandom; data_wdata = $urandom; bus_rdata = $urandom;
        tick(); tick();
        @(negedge clk);
        total++; if ({oks, bus_req, bus_wr, bus_size, bus_addr, bus_wdata} !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {oks, bus_req, bus_wr, bus_size, bus_addr, bus_wdata}); end
        total++; if (inst_rdata !== bus_rdata || data_rdata !== bus_rdata) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=%h", inst_rdata, data_rdata, bus_rdata); end
        tick(); rst = 0; quiet(); bus_addr_ok = 1; bus_data_ok = 1;
        @(negedge clk);
        total++; if ({oks, bus_req} !== 5'b0) begin bad++; $display("FAIL idle_ignore got=%b exp=00000", {oks, bus_req}); end
        tick(); quiet();
        m_last = OWN_INST;
    endtask
    task automatic test_single_read();
        tick(); data_req = 1; data_size = SZ_WORD; data_addr = 32'h100;
        @(negedge clk);
        total++; if ({bus_req, oks} !== 5'b0) begin bad++; $display("FAIL read_c0 got=%b exp=00000", {bus_req, oks}); end
        tick();
        @(negedge clk);
        total++; if ({bus_req, bus_wr, bus_size, bus_addr, oks} !== {1'b1, 1'b0, 2'b10, 32'h100, 4'b0}) begin bad++; $display("FAIL read_c1 got=%b %b %b %h %b exp=1 0 10 100 0000", bus_req, bus_wr, bus_size, bus_addr, oks); end
        tick(); bus_addr_ok = 1;
        @(negedge clk);
        total++; if (oks !== 4'b0010) begin bad++; $display("FAIL read_addr_ok got=%b exp=0010", oks); end
        tick(); bus_addr_ok = 0; data_req = 0;
        @(negedge clk);
        total++; if ({bus_req, oks} !== 5'b0) begin bad++; $display("FAIL read_c3 got=%b exp=00000", {bus_req, oks}); end
        tick(); bus_data_ok = 1; bus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        total++; if (oks !== 4'b0001) begin bad++; $display("FAIL read_data_ok got=%b exp=0001", oks); end
        total++; if (data_rdata !== 32'hDEADBEEF || inst_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL read_rdata got=%h/%h exp=deadbeef", data_rdata, inst_rdata); end
        tick(); quiet();
        m_last = OWN_DATA;
    endtask
    task automatic test_combined();
        logic [31:0] rd;
        tick(); inst_req = 1; inst_addr = 32'hBFC00000; inst_size = SZ_WORD;
        tick(); bus_addr_ok = 1; bus_data_ok = 1; rd = $urandom; bus_rdata = rd;
        @(negedge clk);
        total++; if ({bus_req, bus_addr, oks} !== {1'b1, 32'hBFC00000, 4'b1100}) begin bad++; $display("FAIL comb_pulse got=%b %h %b exp=1 bfc00000 1100", bus_req, bus_addr, oks); end
        total++; if (inst_rdata !== rd) begin bad++; $display("FAIL comb_rdata got=%h exp=%h", inst_rdata, rd); end
        tick(); inst_req = 0;
        @(negedge clk);
        total++; if ({bus_req, oks} !== 5'b0) begin bad++; $display("FAIL comb_idle got=%b exp=00000", {bus_req, oks}); end
        tick(); quiet();
        m_last = OWN_INST;
    endtask
    task automatic test_write_lock();
        tick(); data_req = 1; data_wr = 1; data_size = SZ_BYTE; data_addr = 32'h3; data_wdata = 32'hAA;
        for (int k = 0; k < 3; k++) begin
            tick(); bus_data_ok = k[0]; inst_req = 1; inst_addr = 32'h40; inst_size = SZ_HALF; inst_wdata = 32'h55;
            @(negedge clk);
            total++; if ({bus_req, bus_wr, bus_size, bus_addr, bus_wdata, oks} !== {1'b1, 1'b1, 2'b00, 32'h3, 32'hAA, 4'b0}) begin bad++; $display("FAIL write_addr%0d got=%b %b %b %h %h %b", k, bus_req, bus_wr, bus_size, bus_addr, bus_wdata, oks); end
        end
        tick(); bus_addr_ok = 1; bus_data_ok = 0;
        @(negedge clk);
        total++; if ({bus_wr, bus_addr, oks} !== {1'b1, 32'h3, 4'b0010}) begin bad++; $display("FAIL write_accept got=%b %h %b exp=1 3 0010", bus_wr, bus_addr, oks); end
        tick(); data_req = 0; bus_addr_ok = 1;
        @(negedge clk);
        total++; if ({bus_req, oks} !== 5'b0) begin bad++; $display("FAIL write_data_wait got=%b exp=00000", {bus_req, oks}); end
        tick(); bus_addr_ok = 0; bus_data_ok = 1;
        @(negedge clk);
        total++; if (oks !== 4'b0001) begin bad++; $display("FAIL write_done got=%b exp=0001", oks); end
        tick(); bus_data_ok = 0;
        @(negedge clk);
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL lock_idle got=%b exp=0", bus_req); end
        tick(); bus_addr_ok = 1; bus_data_ok = 1;
        @(negedge clk);
        total++; if ({bus_req, bus_wr, bus_size, bus_addr, oks} !== {1'b1, 1'b0, 2'b01, 32'h40, 4'b1100}) begin bad++; $display("FAIL lock_inst got=%b %b %b %h %b", bus_req, bus_wr, bus_size, bus_addr, oks); end
        tick(); quiet();
        m_last = OWN_INST;
    endtask
    task automatic test_abort();
        tick(); data_req = 1; data_addr = 32'h200;
        tick();
        @(negedge clk);
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL abort_req got=%b exp=1", bus_req); end
        tick(); data_req = 0; bus_addr_ok = 1; bus_data_ok = 1;
        @(negedge clk);
        total++; if ({bus_req, oks} !== 5'b0) begin bad++; $display("FAIL abort_drop got=%b exp=00000", {bus_req, oks}); end
        tick(); bus_addr_ok = 0; bus_data_ok = 0; inst_req = 1; inst_addr = 32'h80;
        @(negedge clk);
        total++; if ({bus_req, oks} !== 5'b0) begin bad++; $display("FAIL abort_idle got=%b exp=00000", {bus_req, oks}); end
        tick(); bus_addr_ok = 1; bus_data_ok = 1;
        @(negedge clk);
        total++; if ({bus_req, bus_addr, oks} !== {1'b1, 32'h80, 4'b1100}) begin bad++; $display("FAIL abort_regrant got=%b %h %b exp=1 80 1100", bus_req, bus_addr, oks); end
        tick(); quiet();
        m_last = OWN_INST;
    endtask
    task automatic test_reset_mid();
        tick(); data_req = 1; data_addr = 32'h300;
        tick(); bus_addr_ok = 1;
        tick(); bus_addr_ok = 0; data_req = 0; rst = 1;
        tick(); rst = 0; bus_data_ok = 1; bus_rdata = 32'h1234;
        @(negedge clk);
        total++; if ({bus_req, oks} !== 5'b0) begin bad++; $display("FAIL rstmid_next got=%b exp=00000", {bus_req, oks}); end
        tick();
        @(negedge clk);
        total++; if ({bus_req, oks} !== 5'b0) begin bad++; $display("FAIL rstmid_later got=%b exp=00000", {bus_req, oks}); end
        tick(); quiet();
        m_last = OWN_INST;
    endtask
    task automatic test_tie();
        owner_e exp;
        do_reset();
        inst_req = 1; inst_addr = 32'h1000; data_req = 1; data_addr = 32'h2000;
        for (int g = 0; g < 4; g++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp = g[0] ? OWN_INST : OWN_DATA;
`else
            exp = OWN_DATA;
`endif
            @(negedge clk);
            total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL tie_slot%0d got=%b exp=0", g, bus_req); end
            tick(); bus_addr_ok = 1; bus_data_ok = 1;
            @(negedge clk);
            total++; if (bus_addr !== (exp == OWN_DATA ? 32'h2000 : 32'h1000) || oks !== (exp == OWN_DATA ? 4'b0011 : 4'b1100)) begin bad++; $display("FAIL tie_grant%0d got=%h %b exp_owner=%s", g, bus_addr, oks, exp.name()); end
            tick(); bus_addr_ok = 0; bus_data_ok = 0;
            m_last = exp;
        end
        quiet();
    endtask
    task automatic test_random();
        owner_e exp, prev;
        logic comb, ew;
        logic [1:0] esz;
        logic [31:0] ea, ewd;
        int wa, wb;
        prev = OWN_INST;
        for (int t = 0; t < 60; t++) begin
            tick();
            if (t > 0) begin
                if (prev == OWN_DATA) data_req = 0; else inst_req = 0;
            end
            bus_addr_ok = 1'($urandom_range(0, 1)); bus_data_ok = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
            if (!inst_req && $urandom_range(0, 1) == 1) begin
                inst_req = 1; inst_wr = 1'($urandom_range(0, 1)); inst_size = 2'($urandom_range(0, 2)); inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (!data_req && ($urandom_range(0, 1) == 1 || !inst_req)) begin
                data_req = 1; data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2)); data_addr = $urandom; data_wdata = $urandom;
            end
            exp = model_pick(inst_req, data_req, m_last);
            m_last = exp;
            prev = exp;
            {ew, esz, ea, ewd} = exp == OWN_DATA ? {data_wr, data_size, data_addr, data_wdata} : {inst_wr, inst_size, inst_addr, inst_wdata};
            @(negedge clk);
            total++; if ({bus_req, oks} !== 5'b0) begin bad++; $display("FAIL rnd_idle%0d got=%b exp=00000", t, {bus_req, oks}); end
            wa = $urandom_range(0, 2);
            comb = 0;
            for (int k = 0; k <= wa; k++) begin
                tick();
                bus_addr_ok = (k == wa); bus_data_ok = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
                comb = (k == wa) && bus_data_ok;
                @(negedge clk);
                total++; if ({bus_req, bus_wr, bus_size, bus_addr, bus_wdata} !== {1'b1, ew, esz, ea, ewd}) begin bad++; $display("FAIL rnd_fwd%0d got=%b %b %b %h %h exp=1 %b %b %h %h", t, bus_req, bus_wr, bus_size, bus_addr, bus_wdata, ew, esz, ea, ewd); end
                total++; if (oks !== (k != wa ? 4'b0 : exp == OWN_DATA ? {3'b001, comb} : {1'b1, comb, 2'b00})) begin bad++; $display("FAIL rnd_aok%0d got=%b owner=%s comb=%b", t, oks, exp.name(), comb); end
            end
            if (!comb) begin
                wb = $urandom_range(0, 2);
                for (int k = 0; k <= wb; k++) begin
                    tick();
                    if (exp == OWN_DATA) data_req = 0; else inst_req = 0;
                    bus_addr_ok = 1'($urandom_range(0, 1)); bus_data_ok = (k == wb); bus_rdata = $urandom;
                    @(negedge clk);
                    total++; if ({bus_req, oks} !== {1'b0, k != wb ? 4'b0 : exp == OWN_DATA ? 4'b0001 : 4'b0100}) begin bad++; $display("FAIL rnd_dok%0d got=%b owner=%s", t, {bus_req, oks}, exp.name()); end
                    total++; if ((exp == OWN_DATA ? data_rdata : inst_rdata) !== bus_rdata) begin bad++; $display("FAIL rnd_rdata%0d got=%h exp=%h", t, exp == OWN_DATA ? data_rdata : inst_rdata, bus_rdata); end
                end
            end
        end
        tick(); quiet();
    endtask
    initial begin
        quiet();
        rst = 1;
        m_last = OWN_INST;
        test_reset();
        test_single_read();
        test_combined();
        test_write_lock();
        test_abort();
        test_reset_mid();
        test_tie();
        do_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
